// File: rtl/imem_responder.sv
// imem_responder: word-addressed memory that answers the 32-bit processor's
// bus. It has a preload port used during LOAD, a read pipeline of LATENCY
// stages, saturating access counters, a sticky address error, and a halt latch
// driven by sys_dne.
module imem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      addr,
    input  logic             rw,
    input  logic [31:0]      out,
    input  logic             sys_dne,
    input  logic             start,
    input  logic             load_en,
    input  logic [AW-1:0]    load_addr,
    input  logic [31:0]      load_data,
    output logic [31:0]      instruction,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count
);

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   load_act;
    logic   run_act;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]     idx;
    logic              addr_err;
    logic              rd_issue;
    logic              wr_issue;

    logic [DATA_W-1:0] rd_data_p [LATENCY];
    logic              vld_p     [LATENCY];

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Decode the processor request. An erroring read still issues (it returns
    // zero). An erroring write is dropped.
    always_comb begin
        idx      = addr[AW+1:2];
        addr_err = (addr[1:0] != 2'b00) || (addr[31:AW+2] != '0);
        rd_issue = run_act && rw;
        wr_issue = run_act && !rw && !addr_err;
    end

    // State register; reset always returns to LOAD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_LOAD;
        else       state <= state_nxt;
    end

    // Next state: start leaves LOAD, sys_dne leaves RUN, HALT is left only by reset.
    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD:  if (start)   state_nxt = S_RUN;
            S_RUN:   if (sys_dne) state_nxt = S_HALT;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_LOAD;
        endcase
    end

    // State decode used by the datapath and exported as halted.
    always_comb begin
        load_act = (state == S_LOAD);
        run_act  = (state == S_RUN);
        halted   = (state == S_HALT);
    end

    // Memory writes: the preload port in LOAD, processor writes in RUN.
    always_ff @(posedge clk) begin
        if (load_act && load_en) mem[load_addr] <= load_data;
        else if (wr_issue)       mem[idx]       <= out;
    end

    // p0 captures the read word (zero on an address error); later stages delay it.
    always_ff @(posedge clk) begin
        rd_data_p[0] <= addr_err ? '0 : mem[idx];
        for (int i = 1; i < LATENCY; i++) rd_data_p[i] <= rd_data_p[i-1];
    end

    // Read valids, instruction output, sticky error and counters. Valids keep
    // draining in HALT because rd_issue is low there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) vld_p[i] <= 1'b0;
            instruction <= '0;
            err         <= 1'b0;
            rd_count    <= '0;
            wr_count    <= '0;
        end else begin
            vld_p[0] <= rd_issue;
            for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
            // Output stage: the result leaves p[LATENCY-1] into instruction.
            if (vld_p[LATENCY-1]) instruction <= rd_data_p[LATENCY-1];
            if (run_act && addr_err) err <= 1'b1;
            if (rd_issue) rd_count <= sat_inc(rd_count);
            if (wr_issue) wr_count <= sat_inc(wr_count);
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: LATENCY 1, 2 and 3 instances share one stimulus stream.
module tb_imem_responder;

    localparam int DEPTH = 256;
    localparam int CNT_W = 4;
    localparam int NDUT  = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0;
    logic        rw = 1'b0;
    logic [31:0] out = '0;
    logic        sys_dne = 1'b0;
    logic        start = 1'b0;
    logic        load_en = 1'b0;
    logic [7:0]  load_addr = '0;
    logic [31:0] load_data = '0;

    logic [31:0]      instr    [NDUT];
    logic             halted_v [NDUT];
    logic             err_v    [NDUT];
    logic [CNT_W-1:0] rdc      [NDUT];
    logic [CNT_W-1:0] wrc      [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        imem_responder #(.DEPTH(DEPTH), .LATENCY(g + 1), .CNT_W(CNT_W)) u_dut (
            .clk(clk), .reset(reset), .addr(addr), .rw(rw), .out(out),
            .sys_dne(sys_dne), .start(start), .load_en(load_en),
            .load_addr(load_addr), .load_data(load_data),
            .instruction(instr[g]), .halted(halted_v[g]), .err(err_v[g]),
            .rd_count(rdc[g]), .wr_count(wrc[g])
        );
    end

    typedef struct {
        int          issue;
        logic [31:0] data;
    } sb_t;

    sb_t         sbq[$];
    logic [31:0] mdl [DEPTH];
    logic [31:0] exp_instr [NDUT];
    int          m_state;   // 0 LOAD, 1 RUN, 2 HALT
    logic        m_err;
    int          m_rd, m_wr;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= CMAX) ? v : v + 1;
    endfunction

    task automatic check_all();
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("instr_L%0d", k + 1), instr[k], exp_instr[k]);
            chk($sformatf("halted_L%0d", k + 1), 32'(halted_v[k]), 32'(m_state == 2));
            chk($sformatf("err_L%0d", k + 1), 32'(err_v[k]), 32'(m_err));
            chk($sformatf("rd_count_L%0d", k + 1), 32'(rdc[k]), 32'(m_rd));
            chk($sformatf("wr_count_L%0d", k + 1), 32'(wrc[k]), 32'(m_wr));
        end
    endtask

    // One clock: a result becomes due LATENCY edges after its sampling edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        foreach (sbq[i])
            for (int k = 0; k < NDUT; k++)
                if (sbq[i].issue + k + 1 == cyc) exp_instr[k] = sbq[i].data;
        while (sbq.size() > 0 && sbq[0].issue + NDUT <= cyc) void'(sbq.pop_front());
        check_all();
    endtask

    task automatic bus(input logic r, input logic [31:0] a, input logic [31:0] d, input logic dne);
        logic bad;
        sb_t  e;
        rw = r; addr = a; out = d; sys_dne = dne; start = 1'b0; load_en = 1'b0;
        if (m_state == 1) begin
            bad = (a[1:0] != 2'b00) || (a[31:10] != '0);
            if (bad) m_err = 1'b1;
            if (r) begin
                e.issue = cyc + 1;
                e.data  = bad ? 32'h0 : mdl[a[9:2]];
                sbq.push_back(e);
                m_rd = sat(m_rd);
            end else if (!bad) begin
                mdl[a[9:2]] = d;
                m_wr = sat(m_wr);
            end
            if (dne) m_state = 2;
        end
        step();
        sys_dne = 1'b0;
    endtask

    task automatic load(input int i, input logic [31:0] d, input logic st);
        load_en = 1'b1; load_addr = i[7:0]; load_data = d; start = st;
        rw = 1'b1; addr = 32'h0; sys_dne = 1'b0;
        if (m_state == 0) begin
            mdl[i] = d;
            if (st) m_state = 1;
        end
        step();
        load_en = 1'b0; start = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1; load_en = 1'b0; rw = 1'b1; addr = 32'h0;
        if (m_state == 0) m_state = 1;
        step();
        start = 1'b0;
    endtask

    // Asynchronous reset between edges; outputs must clear before the next edge.
    task automatic apply_reset();
        reset = 1'b1;
        #1;
        m_state = 0; m_err = 1'b0; m_rd = 0; m_wr = 0;
        sbq.delete();
        for (int k = 0; k < NDUT; k++) exp_instr[k] = '0;
        check_all();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        for (int k = 0; k < NDUT; k++) exp_instr[k] = '0;
        m_state = 0; m_err = 1'b0; m_rd = 0; m_wr = 0;

        // Reset state.
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;

        // Preload words 0..7, then show that the processor bus is ignored in LOAD.
        load(0, 32'h29E0E756, 1'b0);
        load(1, 32'h35E4A163, 1'b0);
        for (int i = 2; i < 8; i++) load(i, 32'hA5A50000 | 32'(i), 1'b0);
        bus(1'b0, 32'h4, 32'hDEADBEEF, 1'b0);
        bus(1'b1, 32'h0, 32'h0, 1'b0);
        // A load and start in the same cycle: the load lands, then RUN.
        load(8, 32'h0BAD0008, 1'b1);

        // Basic reads, then back-to-back reads.
        bus(1'b1, 32'h0, 32'h0, 1'b0);
        bus(1'b1, 32'h4, 32'h0, 1'b0);
        bus(1'b1, 32'h0, 32'h0, 1'b0);
        bus(1'b1, 32'h4, 32'h0, 1'b0);
        bus(1'b1, 32'h8, 32'h0, 1'b0);

        // A write followed by a read of the same word.
        bus(1'b0, 32'h8, 32'hFFFFA142, 1'b0);
        bus(1'b1, 32'h8, 32'h0, 1'b0);

        // Misaligned read and out-of-range write, then confirm memory is untouched.
        bus(1'b1, 32'h00000006, 32'h0, 1'b0);
        bus(1'b0, 32'h00001000, 32'h12345678, 1'b0);
        bus(1'b1, 32'h0, 32'h0, 1'b0);
        bus(1'b1, 32'h20, 32'h0, 1'b0);

        // Mixed random traffic with rw toggling, then enough reads to saturate.
        for (int n = 0; n < 24; n++)
            bus(1'($urandom_range(0, 1)), 32'($urandom_range(0, 8)) << 2, $urandom, 1'b0);
        for (int n = 0; n < 16; n++)
            bus(1'b1, 32'($urandom_range(0, 8)) << 2, 32'h0, 1'b0);
        for (int n = 0; n < 16; n++)
            bus(1'b0, 32'($urandom_range(4, 8)) << 2, $urandom, 1'b0);

        // Halt on a write; later bus activity is ignored and reads drain out.
        bus(1'b1, 32'h4, 32'h0, 1'b0);
        bus(1'b0, 32'hC, 32'h00005C62, 1'b1);
        bus(1'b0, 32'hC, 32'hFFFF954C, 1'b0);
        bus(1'b1, 32'hC, 32'h0, 1'b0);
        bus(1'b1, 32'h0, 32'h0, 1'b0);
        step();

        // Leave HALT via reset; in LOAD a read is still ignored.
        apply_reset();
        bus(1'b1, 32'hC, 32'h0, 1'b0);
        start_pulse();
        bus(1'b1, 32'hC, 32'h0, 1'b0);
        bus(1'b1, 32'h0, 32'h0, 1'b0);
        // Reset with reads in flight.
        apply_reset();
        step();

        // Memory survives reset.
        start_pulse();
        bus(1'b1, 32'h0, 32'h0, 1'b0);
        bus(1'b1, 32'h4, 32'h0, 1'b0);
        bus(1'b1, 32'hC, 32'h0, 1'b1);
        for (int n = 0; n < 4; n++) step();
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
